// File: rtl/turn_controller.sv
// -----------------------------------------------------------------------------
// turn_controller
//
// Runs the play phase of the memory game. It owns the board cursor, accepts
// card selections, and writes single entries into the external card-array
// register. It compares each pair of cards. A mismatched pair stays face-up
// for HOLD_CYCLES cycles. The block also keeps both scores, switches turns
// and detects the end of the game.
//
// Ports
//   clk          system clock (50 MHz)
//   rst          synchronous, active-high reset
//   enable       high while the top level is in a play state
//   btn_left     one-cycle pulse: move cursor left (wraps 0 -> last)
//   btn_right    one-cycle pulse: move cursor right (wraps last -> 0)
//   btn_sel      one-cycle pulse: select the card under the cursor
//   timeout      turn timer expired (level)
//   arr_in       flattened card array, entry i = arr_in[5i+4:5i],
//                {status[1:0], symbol[2:0]}; status 00 hidden, 01 face-up,
//                10 matched
//   cursor       highlighted card index
//   wr_en        one-cycle write strobe to the card-array register
//   wr_idx       entry to write
//   wr_data      new entry value (new status, unchanged symbol)
//   turno_de     01 = player 1, 10 = player 2, 00 = idle
//   puntajeJ1    pairs found by player 1
//   puntajeJ2    pairs found by player 2
//   reset_timer  one-cycle pulse at every turn start
//   game_over    high once every pair is matched
//   ganador      00 none, 01 player 1, 10 player 2, 11 tie
// -----------------------------------------------------------------------------
module turn_controller #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int N_PAIRS     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   btn_left,
  input  logic                   btn_right,
  input  logic                   btn_sel,
  input  logic                   timeout,
  input  logic [10*N_PAIRS-1:0]  arr_in,
  output logic [3:0]             cursor,
  output logic                   wr_en,
  output logic [3:0]             wr_idx,
  output logic [4:0]             wr_data,
  output logic [1:0]             turno_de,
  output logic [3:0]             puntajeJ1,
  output logic [3:0]             puntajeJ2,
  output logic                   reset_timer,
  output logic                   game_over,
  output logic [1:0]             ganador
);

  localparam int N_CARDS = 2 * N_PAIRS;
  // At least one bit, so that HOLD_CYCLES = 1 still yields a legal counter.
  localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [1:0] ST_HIDDEN  = 2'b00;
  localparam logic [1:0] ST_FACEUP  = 2'b01;
  localparam logic [1:0] ST_MATCHED = 2'b10;

  localparam logic [1:0] PLAYER_1   = 2'b01;
  localparam logic [1:0] PLAYER_2   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_FIRST,
    S_WAIT_SECOND,
    S_COMPARE,
    S_MATCH1,
    S_MATCH2,
    S_HOLD,
    S_HIDE1,
    S_HIDE2,
    S_DONE
  } state_t;

  state_t              state, state_nxt;

  logic [3:0]          cursor_nxt;
  logic                wr_en_nxt;
  logic [3:0]          wr_idx_nxt;
  logic [4:0]          wr_data_nxt;
  logic [1:0]          turno_nxt;
  logic [3:0]          score1_nxt, score2_nxt;
  logic                reset_timer_nxt;
  logic                game_over_nxt;
  logic [1:0]          ganador_nxt;

  logic [3:0]          first_idx, first_idx_nxt;
  logic [3:0]          second_idx, second_idx_nxt;
  logic [2:0]          first_sym, first_sym_nxt;
  logic [2:0]          second_sym, second_sym_nxt;
  logic [3:0]          pair_cnt, pair_cnt_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;

  logic [4:0]          cards [N_CARDS];
  logic [4:0]          cur_card;
  logic                cur_hidden;

  // Unpack the flat bus so the card under the cursor can be indexed directly.
  always_comb begin
    for (int i = 0; i < N_CARDS; i++) begin
      cards[i] = arr_in[5*i +: 5];
    end
  end

  assign cur_card   = cards[cursor];
  assign cur_hidden = (cur_card[4:3] == ST_HIDDEN);

  function automatic logic [1:0] other_player(input logic [1:0] p);
    return (p == PLAYER_1) ? PLAYER_2 : PLAYER_1;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case statement. A path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_nxt       = state;
    cursor_nxt      = cursor;
    wr_en_nxt       = 1'b0;
    wr_idx_nxt      = wr_idx;
    wr_data_nxt     = wr_data;
    turno_nxt       = turno_de;
    score1_nxt      = puntajeJ1;
    score2_nxt      = puntajeJ2;
    reset_timer_nxt = 1'b0;
    game_over_nxt   = game_over;
    ganador_nxt     = ganador;
    first_idx_nxt   = first_idx;
    second_idx_nxt  = second_idx;
    first_sym_nxt   = first_sym;
    second_sym_nxt  = second_sym;
    pair_cnt_nxt    = pair_cnt;
    hold_cnt_nxt    = hold_cnt;

    // The cursor moves only while a card can be picked. A select in the same
    // cycle takes priority, and pressing both directions cancels out.
    if (enable && (state == S_WAIT_FIRST || state == S_WAIT_SECOND) &&
        !btn_sel && (btn_left ^ btn_right)) begin
      if (btn_right) begin
        cursor_nxt = (cursor == 4'(N_CARDS - 1)) ? 4'd0 : cursor + 4'd1;
      end else begin
        cursor_nxt = (cursor == 4'd0) ? 4'(N_CARDS - 1) : cursor - 4'd1;
      end
    end

    if (!enable) begin
      // Leaving play aborts the turn. Scores and the winner stay visible.
      state_nxt     = S_IDLE;
      turno_nxt     = 2'b00;
      game_over_nxt = 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          score1_nxt      = 4'd0;
          score2_nxt      = 4'd0;
          pair_cnt_nxt    = 4'd0;
          ganador_nxt     = 2'b00;
          game_over_nxt   = 1'b0;
          turno_nxt       = PLAYER_1;
          reset_timer_nxt = 1'b1;
          state_nxt       = S_WAIT_FIRST;
        end

        S_WAIT_FIRST: begin
          if (timeout) begin
            turno_nxt       = other_player(turno_de);
            reset_timer_nxt = 1'b1;
          end else if (btn_sel && cur_hidden) begin
            wr_en_nxt     = 1'b1;
            wr_idx_nxt    = cursor;
            wr_data_nxt   = {ST_FACEUP, cur_card[2:0]};
            first_idx_nxt = cursor;
            first_sym_nxt = cur_card[2:0];
            state_nxt     = S_WAIT_SECOND;
          end
        end

        S_WAIT_SECOND: begin
          if (timeout) begin
            wr_en_nxt       = 1'b1;
            wr_idx_nxt      = first_idx;
            wr_data_nxt     = {ST_HIDDEN, first_sym};
            turno_nxt       = other_player(turno_de);
            reset_timer_nxt = 1'b1;
            state_nxt       = S_WAIT_FIRST;
          end else if (btn_sel && cur_hidden && (cursor != first_idx)) begin
            // The first card's face-up write lands in arr_in two cycles after
            // its select. The index test covers that gap.
            wr_en_nxt      = 1'b1;
            wr_idx_nxt     = cursor;
            wr_data_nxt    = {ST_FACEUP, cur_card[2:0]};
            second_idx_nxt = cursor;
            second_sym_nxt = cur_card[2:0];
            state_nxt      = S_COMPARE;
          end
        end

        S_COMPARE: begin
          if (first_sym == second_sym) begin
            wr_en_nxt   = 1'b1;
            wr_idx_nxt  = first_idx;
            wr_data_nxt = {ST_MATCHED, first_sym};
            state_nxt   = S_MATCH1;
          end else begin
            hold_cnt_nxt = '0;
            state_nxt    = S_HOLD;
          end
        end

        S_MATCH1: begin
          wr_en_nxt   = 1'b1;
          wr_idx_nxt  = second_idx;
          wr_data_nxt = {ST_MATCHED, second_sym};
          state_nxt   = S_MATCH2;
        end

        S_MATCH2: begin
          if (turno_de == PLAYER_1) begin
            score1_nxt = puntajeJ1 + 4'd1;
          end else begin
            score2_nxt = puntajeJ2 + 4'd1;
          end
          pair_cnt_nxt = pair_cnt + 4'd1;
          if (pair_cnt_nxt == 4'(N_PAIRS)) begin
            game_over_nxt = 1'b1;
            if (score1_nxt > score2_nxt) begin
              ganador_nxt = 2'b01;
            end else if (score2_nxt > score1_nxt) begin
              ganador_nxt = 2'b10;
            end else begin
              ganador_nxt = 2'b11;
            end
            state_nxt = S_DONE;
          end else begin
            // The same player continues after a match.
            reset_timer_nxt = 1'b1;
            state_nxt       = S_WAIT_FIRST;
          end
        end

        S_HOLD: begin
          // The HOLD state lasts exactly HOLD_CYCLES cycles (count 0..N-1).
          if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
            wr_en_nxt   = 1'b1;
            wr_idx_nxt  = first_idx;
            wr_data_nxt = {ST_HIDDEN, first_sym};
            state_nxt   = S_HIDE1;
          end else begin
            hold_cnt_nxt = hold_cnt + 1'b1;
          end
        end

        S_HIDE1: begin
          wr_en_nxt   = 1'b1;
          wr_idx_nxt  = second_idx;
          wr_data_nxt = {ST_HIDDEN, second_sym};
          state_nxt   = S_HIDE2;
        end

        S_HIDE2: begin
          turno_nxt       = other_player(turno_de);
          reset_timer_nxt = 1'b1;
          state_nxt       = S_WAIT_FIRST;
        end

        S_DONE: begin
          // Hold the final result until enable drops or reset.
        end

        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cursor      <= 4'd0;
      wr_en       <= 1'b0;
      wr_idx      <= 4'd0;
      wr_data     <= 5'd0;
      turno_de    <= 2'b00;
      puntajeJ1   <= 4'd0;
      puntajeJ2   <= 4'd0;
      reset_timer <= 1'b0;
      game_over   <= 1'b0;
      ganador     <= 2'b00;
      first_idx   <= 4'd0;
      second_idx  <= 4'd0;
      first_sym   <= 3'd0;
      second_sym  <= 3'd0;
      pair_cnt    <= 4'd0;
      hold_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      cursor      <= cursor_nxt;
      wr_en       <= wr_en_nxt;
      wr_idx      <= wr_idx_nxt;
      wr_data     <= wr_data_nxt;
      turno_de    <= turno_nxt;
      puntajeJ1   <= score1_nxt;
      puntajeJ2   <= score2_nxt;
      reset_timer <= reset_timer_nxt;
      game_over   <= game_over_nxt;
      ganador     <= ganador_nxt;
      first_idx   <= first_idx_nxt;
      second_idx  <= second_idx_nxt;
      first_sym   <= first_sym_nxt;
      second_sym  <= second_sym_nxt;
      pair_cnt    <= pair_cnt_nxt;
      hold_cnt    <= hold_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_turn_controller.sv
// -----------------------------------------------------------------------------
// tb_turn_controller
//
// Directed bench for turn_controller with HOLD_CYCLES = 4. The bench holds the
// card-array register itself. The register applies each wr_en write on a clock
// edge, so arr_in shows the write two edges after the select.
//
// Board layout (index: symbol). Pairs are 0/8, 1/10, 2/9, 3/11, 4/12, 5/13,
// 6/14 and 7/15.
//   0:1  1:2  2:5  3:0  4:3  5:4  6:6  7:7
//   8:1  9:5 10:2 11:0 12:3 13:4 14:6 15:7
// -----------------------------------------------------------------------------
module tb_turn_controller;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        btn_left;
  logic        btn_right;
  logic        btn_sel;
  logic        timeout;
  logic [79:0] arr;
  logic [3:0]  cursor;
  logic        wr_en;
  logic [3:0]  wr_idx;
  logic [4:0]  wr_data;
  logic [1:0]  turno_de;
  logic [3:0]  puntajeJ1;
  logic [3:0]  puntajeJ2;
  logic        reset_timer;
  logic        game_over;
  logic [1:0]  ganador;

  logic        load;
  logic [79:0] load_val;

  int errors = 0;
  int checks = 0;
  int cur_model = 0;

  int sym_tbl [16] = '{1, 2, 5, 0, 3, 4, 6, 7, 1, 5, 2, 0, 3, 4, 6, 7};

  turn_controller #(
    .HOLD_CYCLES (4),
    .N_PAIRS     (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_sel     (btn_sel),
    .timeout     (timeout),
    .arr_in      (arr),
    .cursor      (cursor),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_data     (wr_data),
    .turno_de    (turno_de),
    .puntajeJ1   (puntajeJ1),
    .puntajeJ2   (puntajeJ2),
    .reset_timer (reset_timer),
    .game_over   (game_over),
    .ganador     (ganador)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The card-array register driven by the controller's write port.
  always @(posedge clk) begin
    if (load) begin
      arr <= load_val;
    end else if (wr_en) begin
      arr[int'(wr_idx)*5 +: 5] <= wr_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_layout();
    for (int i = 0; i < 16; i++) begin
      load_val[i*5 +: 5] = {2'b00, 3'(sym_tbl[i])};
    end
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic move_to(input int target);
    int n;
    n = (target - cur_model + 16) % 16;
    if (n > 0) begin
      btn_right = 1'b1;
      repeat (n) tick();
      btn_right = 1'b0;
    end
    cur_model = target;
    check("cursor_move", 32'(cursor), 32'(target));
  endtask

  task automatic sel();
    btn_sel = 1'b1;
    tick();
    btn_sel = 1'b0;
  endtask

  task automatic check_wr(input string tag, input int idx, input int data);
    check({tag, "_en"},   32'(wr_en),   1);
    check({tag, "_idx"},  32'(wr_idx),  32'(idx));
    check({tag, "_data"}, 32'(wr_data), 32'(data));
  endtask

  // A full matching turn: two selects, then COMPARE, MATCH1 and MATCH2.
  task automatic play_pair(input int a, input int b);
    move_to(a);
    sel();
    move_to(b);
    sel();
    repeat (3) tick();
  endtask

  task automatic turn_timeout(input int new_player);
    timeout = 1'b1;
    tick();
    timeout = 1'b0;
    check("to_turno", 32'(turno_de), 32'(new_player));
    check("to_rtimer", 32'(reset_timer), 1);
  endtask

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    btn_left  = 1'b0;
    btn_right = 1'b0;
    btn_sel   = 1'b0;
    timeout   = 1'b0;
    load      = 1'b0;
    load_val  = '0;

    // ---------------- reset / idle ----------------
    repeat (2) tick();
    check("rst_cursor", 32'(cursor), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_idx", 32'(wr_idx), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_turno", 32'(turno_de), 0);
    check("rst_j1", 32'(puntajeJ1), 0);
    check("rst_j2", 32'(puntajeJ2), 0);
    check("rst_rtimer", 32'(reset_timer), 0);
    check("rst_over", 32'(game_over), 0);
    check("rst_ganador", 32'(ganador), 0);
    load_layout();
    rst = 1'b0;

    enable = 1'b1;
    tick();
    check("start_turno", 32'(turno_de), 'b01);
    check("start_rtimer", 32'(reset_timer), 1);
    tick();
    check("start_rtimer_low", 32'(reset_timer), 0);

    // ---------------- cursor wrap ----------------
    btn_left = 1'b1;
    tick();
    btn_left = 1'b0;
    check("wrap_left", 32'(cursor), 15);
    btn_right = 1'b1;
    tick();
    btn_right = 1'b0;
    check("wrap_right", 32'(cursor), 0);
    btn_left  = 1'b1;
    btn_right = 1'b1;
    tick();
    btn_left  = 1'b0;
    btn_right = 1'b0;
    check("both_dirs", 32'(cursor), 0);

    // Select with a move in the same cycle: the select wins.
    move_to(3);
    btn_sel   = 1'b1;
    btn_right = 1'b1;
    tick();
    btn_sel   = 1'b0;
    btn_right = 1'b0;
    check_wr("sel_prio", 3, 'b01000);
    check("sel_prio_cursor", 32'(cursor), 3);
    move_to(11);
    sel();
    repeat (3) tick();
    check("match0_j1", 32'(puntajeJ1), 1);

    // ---------------- match 2/9 (symbol 5) ----------------
    move_to(2);
    sel();
    check_wr("m_first_up", 2, 'b01101);
    move_to(9);
    sel();
    check_wr("m_second_up", 9, 'b01101);
    tick();
    check_wr("m_first_matched", 2, 'b10101);
    tick();
    check_wr("m_second_matched", 9, 'b10101);
    tick();
    check("m_wr_idle", 32'(wr_en), 0);
    check("m_rtimer", 32'(reset_timer), 1);
    check("m_j1", 32'(puntajeJ1), 2);
    check("m_turno", 32'(turno_de), 'b01);

    // ---------------- mismatch 0 (sym 1) / 1 (sym 2) ----------------
    move_to(0);
    sel();
    check_wr("mm_first_up", 0, 'b01001);
    move_to(1);
    sel();
    check_wr("mm_second_up", 1, 'b01010);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mm_hold_no_wr", 32'(wr_en), 0);
    end
    tick();
    check_wr("mm_hide_first", 0, 'b00001);
    tick();
    check_wr("mm_hide_second", 1, 'b00010);
    tick();
    check("mm_wr_idle", 32'(wr_en), 0);
    check("mm_turno", 32'(turno_de), 'b10);
    check("mm_rtimer", 32'(reset_timer), 1);

    // ---------------- timeout in WAIT_SECOND ----------------
    move_to(4);
    sel();
    check_wr("to_first_up", 4, 'b01011);
    tick();
    move_to(12);
    timeout = 1'b1;
    btn_sel = 1'b1;
    tick();
    timeout = 1'b0;
    btn_sel = 1'b0;
    check_wr("to_hide_first", 4, 'b00011);
    check("to_turno_j1", 32'(turno_de), 'b01);
    check("to_rtimer_ws", 32'(reset_timer), 1);

    // Reselecting matched and face-up cards writes nothing.
    move_to(2);
    sel();
    check("resel_matched", 32'(wr_en), 0);
    move_to(5);
    sel();
    check_wr("resel_first", 5, 'b01100);
    tick();
    sel();
    check("resel_faceup", 32'(wr_en), 0);
    move_to(13);
    sel();
    check_wr("resel_second", 13, 'b01100);
    repeat (3) tick();
    check("pair3_j1", 32'(puntajeJ1), 3);

    // ---------------- finish game 1: J1 5, J2 3 ----------------
    play_pair(0, 8);
    play_pair(1, 10);
    check("g1_j1", 32'(puntajeJ1), 5);
    turn_timeout('b10);
    play_pair(4, 12);
    play_pair(6, 14);
    check("g1_not_over", 32'(game_over), 0);
    play_pair(7, 15);
    check("g1_over", 32'(game_over), 1);
    check("g1_ganador", 32'(ganador), 'b01);
    check("g1_j2", 32'(puntajeJ2), 3);
    check("g1_j1_final", 32'(puntajeJ1), 5);
    check("g1_no_rtimer", 32'(reset_timer), 0);

    // Buttons are ignored in DONE.
    sel();
    check("done_no_wr", 32'(wr_en), 0);
    check("done_over", 32'(game_over), 1);

    // Dropping enable returns to idle and keeps the scores.
    enable = 1'b0;
    tick();
    check("off_turno", 32'(turno_de), 0);
    check("off_over", 32'(game_over), 0);
    check("off_j1", 32'(puntajeJ1), 5);
    check("off_ganador", 32'(ganador), 'b01);

    // ---------------- game 2: 4/4 tie ----------------
    load_layout();
    enable = 1'b1;
    tick();
    check("g2_turno", 32'(turno_de), 'b01);
    check("g2_j1_clear", 32'(puntajeJ1), 0);
    check("g2_j2_clear", 32'(puntajeJ2), 0);
    play_pair(3, 11);
    play_pair(2, 9);
    play_pair(0, 8);
    play_pair(1, 10);
    turn_timeout('b10);
    play_pair(4, 12);
    play_pair(5, 13);
    play_pair(6, 14);
    play_pair(7, 15);
    check("g2_over", 32'(game_over), 1);
    check("g2_j1", 32'(puntajeJ1), 4);
    check("g2_j2", 32'(puntajeJ2), 4);
    check("g2_tie", 32'(ganador), 'b11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
